// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: arbiter state encoding and a constant-width helper.
package wb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_GNT0 = 2'd1,
    ARB_GNT1 = 2'd2
  } arb_state_t;

  // Number of bits needed to index 'value' distinct values (clog2(1) == 0).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus watchdog: counts consecutive unterminated strobe cycles and fires at 'timeout'.
module wb_watchdog
  import wb_pkg::*;
#(
  parameter int timeout = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic active,
  output logic fire
);

  localparam int cnt_w = (clog2(timeout + 1) < 1) ? 1 : clog2(timeout + 1);
  localparam logic [cnt_w-1:0] term_cnt = cnt_w'(timeout);
  localparam bit enabled = (timeout != 0);

  logic [cnt_w-1:0] cnt;

  assign fire = enabled && (cnt == term_cnt);

  // The firing cycle itself clears the count so the error is a single pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || !active || fire || !enabled) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + cnt_w'(1);
    end
  end

endmodule

// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone arbiter; grant held for the whole cyc, with bus watchdog.
module wb_arb2
  import wb_pkg::*;
#(
  parameter int adr_width = 32,
  parameter int timeout   = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,

  input  logic [adr_width-1:0] m0_adr_i,
  input  logic [31:0]          m0_dat_i,
  input  logic [3:0]           m0_sel_i,
  input  logic                 m0_we_i,
  input  logic                 m0_cyc_i,
  input  logic                 m0_stb_i,
  output logic [31:0]          m0_dat_o,
  output logic                 m0_ack_o,
  output logic                 m0_err_o,
  output logic                 m0_rty_o,

  input  logic [adr_width-1:0] m1_adr_i,
  input  logic [31:0]          m1_dat_i,
  input  logic [3:0]           m1_sel_i,
  input  logic                 m1_we_i,
  input  logic                 m1_cyc_i,
  input  logic                 m1_stb_i,
  output logic [31:0]          m1_dat_o,
  output logic                 m1_ack_o,
  output logic                 m1_err_o,
  output logic                 m1_rty_o,

  output logic [adr_width-1:0] s_adr_o,
  output logic [31:0]          s_dat_o,
  output logic [3:0]           s_sel_o,
  output logic                 s_we_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  input  logic [31:0]          s_dat_i,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  input  logic                 s_rty_i,

  output logic [1:0]           gnt
);

  arb_state_t state, state_nxt;
  logic       last;
  logic       sel1;
  logic       granted;
  logic       own_cyc;
  logic       own_stb;
  logic       wd_fire;
  logic       wd_active;
  logic       wd_clear;

  // 'last' = 1 out of reset so master 0 wins the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ARB_IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt == ARB_GNT0) begin
        last <= 1'b0;
      end else if (state_nxt == ARB_GNT1) begin
        last <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = last ? ARB_GNT0 : ARB_GNT1;
        end else if (m0_cyc_i) begin
          state_nxt = ARB_GNT0;
        end else if (m1_cyc_i) begin
          state_nxt = ARB_GNT1;
        end
      end
      ARB_GNT0: begin
        if (!m0_cyc_i) state_nxt = m1_cyc_i ? ARB_GNT1 : ARB_IDLE;
      end
      ARB_GNT1: begin
        if (!m1_cyc_i) state_nxt = m0_cyc_i ? ARB_GNT0 : ARB_IDLE;
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign gnt[0]  = (state == ARB_GNT0);
  assign gnt[1]  = (state == ARB_GNT1);
  assign sel1    = gnt[1];
  assign granted = gnt[0] | gnt[1];

  // Idle defaults to master 0 on the address/data side; enables are gated by state.
  always_comb begin
    s_adr_o = sel1 ? m1_adr_i : m0_adr_i;
    s_dat_o = sel1 ? m1_dat_i : m0_dat_i;
    s_sel_o = sel1 ? m1_sel_i : m0_sel_i;
    s_we_o  = sel1 ? m1_we_i  : m0_we_i;
    own_cyc = sel1 ? m1_cyc_i : m0_cyc_i;
    own_stb = sel1 ? m1_stb_i : m0_stb_i;
  end

  assign s_cyc_o = granted & own_cyc;
  assign s_stb_o = granted & own_stb & ~wd_fire;

  // Watchdog sees the pre-fire strobe so the forced-low cycle does not feed back.
  assign wd_active = s_cyc_o & own_stb;
  assign wd_clear  = s_ack_i | s_err_i | s_rty_i;

  wb_watchdog #(
    .timeout (timeout)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wd_clear),
    .active  (wd_active),
    .fire    (wd_fire)
  );

  always_comb begin
    m0_dat_o = s_dat_i;
    m1_dat_o = s_dat_i;
    m0_ack_o = gnt[0] & s_ack_i;
    m0_err_o = gnt[0] & (s_err_i | wd_fire);
    m0_rty_o = gnt[0] & s_rty_i;
    m1_ack_o = gnt[1] & s_ack_i;
    m1_err_o = gnt[1] & (s_err_i | wd_fire);
    m1_rty_o = gnt[1] & s_rty_i;
  end

endmodule

// File: tb/tb_wb_arb2.sv
// Directed self-checking bench for wb_arb2 (watchdog timeout 8, plus a timeout-0 twin).
module tb_wb_arb2;

  logic        clk;
  logic        reset_n;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i, s_rty_i;
  logic [1:0]  gnt;

  logic [31:0] z_m0_dat_o, z_m1_dat_o, z_s_adr_o, z_s_dat_o;
  logic        z_m0_ack_o, z_m0_err_o, z_m0_rty_o, z_m1_ack_o, z_m1_err_o, z_m1_rty_o;
  logic [3:0]  z_s_sel_o;
  logic        z_s_we_o, z_s_cyc_o, z_s_stb_o;
  logic [1:0]  z_gnt;

  int vectors = 0;
  int miscompares = 0;

  wb_arb2 #(.adr_width(32), .timeout(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .s_rty_i(s_rty_i), .gnt(gnt)
  );

  wb_arb2 #(.adr_width(32), .timeout(0)) dut_nowd (
    .clk(clk), .reset_n(reset_n),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(z_m0_dat_o), .m0_ack_o(z_m0_ack_o),
    .m0_err_o(z_m0_err_o), .m0_rty_o(z_m0_rty_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(z_m1_dat_o), .m1_ack_o(z_m1_ack_o),
    .m1_err_o(z_m1_err_o), .m1_rty_o(z_m1_rty_o),
    .s_adr_o(z_s_adr_o), .s_dat_o(z_s_dat_o), .s_sel_o(z_s_sel_o), .s_we_o(z_s_we_o),
    .s_cyc_o(z_s_cyc_o), .s_stb_o(z_s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .s_rty_i(s_rty_i), .gnt(z_gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters;
    m0_cyc_i = 0; m0_stb_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
  endtask

  task automatic test_reset;
    #1;
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    vectors++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin miscompares++; $display("FAIL reset_enables: got cyc=%b stb=%b expected 0 0", s_cyc_o, s_stb_o); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic test_tie;
    m0_adr_i = 32'h0000_1000; m1_adr_i = 32'h4000_2000;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick;
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL tie1_gnt: got %b expected 01", gnt); end
    vectors++; if (s_adr_o !== 32'h0000_1000) begin miscompares++; $display("FAIL tie1_adr: got %h expected 00001000", s_adr_o); end
    s_ack_i = 1;
    #1;
    vectors++; if (m0_ack_o !== 1'b1 || m1_ack_o !== 1'b0) begin miscompares++; $display("FAIL tie1_ack: got m0=%b m1=%b expected 1 0", m0_ack_o, m1_ack_o); end
    tick;
    s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    tick;
    vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL handover_gnt: got %b expected 10", gnt); end
    vectors++; if (s_adr_o !== 32'h4000_2000 || s_stb_o !== 1'b1) begin miscompares++; $display("FAIL handover_slave: got adr=%h stb=%b expected 40002000 1", s_adr_o, s_stb_o); end
    m1_cyc_i = 0; m1_stb_i = 0;
    tick;
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL handover_idle: got %b expected 00", gnt); end
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick;
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL tie2_gnt: got %b expected 01", gnt); end
    idle_masters;
    tick;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick;
    vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL tie3_gnt: got %b expected 10", gnt); end
    idle_masters;
    tick;
  endtask

  task automatic test_single;
    m1_adr_i = 32'h4000_0010; m1_we_i = 0; m1_sel_i = 4'hF;
    m1_cyc_i = 1; m1_stb_i = 1;
    #1;
    vectors++; if (gnt !== 2'b00 || s_cyc_o !== 1'b0) begin miscompares++; $display("FAIL single_latency: got gnt=%b cyc=%b expected 00 0", gnt, s_cyc_o); end
    tick;
    vectors++; if (gnt !== 2'b10) begin miscompares++; $display("FAIL single_gnt: got %b expected 10", gnt); end
    vectors++; if (s_adr_o !== 32'h4000_0010 || s_cyc_o !== 1'b1 || s_stb_o !== 1'b1) begin miscompares++; $display("FAIL single_slave: got adr=%h cyc=%b stb=%b expected 40000010 1 1", s_adr_o, s_cyc_o, s_stb_o); end
    s_ack_i = 1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    vectors++; if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0) begin miscompares++; $display("FAIL single_ack: got m1=%b m0=%b expected 1 0", m1_ack_o, m0_ack_o); end
    vectors++; if (m1_dat_o !== 32'hDEAD_BEEF || m0_dat_o !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL single_dat: got m1=%h m0=%h expected deadbeef deadbeef", m1_dat_o, m0_dat_o); end
    tick;
    idle_masters;
    tick;
    vectors++; if (gnt !== 2'b00) begin miscompares++; $display("FAIL single_release: got %b expected 00", gnt); end
  endtask

  task automatic test_hold;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick;
    for (int i = 0; i < 8; i++) begin
      m0_stb_i = (i % 2 == 0);
      s_ack_i = m0_stb_i;
      #1;
      vectors++; if (gnt !== 2'b01 || m1_ack_o !== 1'b0 || m0_ack_o !== m0_stb_i) begin miscompares++; $display("FAIL hold_beat%0d: got gnt=%b m0_ack=%b m1_ack=%b expected 01 %b 0", i, gnt, m0_ack_o, m1_ack_o, m0_stb_i); end
      tick;
    end
    m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
    tick;
    s_ack_i = 1;
    #1;
    vectors++; if (gnt !== 2'b10 || m1_ack_o !== 1'b1) begin miscompares++; $display("FAIL hold_release: got gnt=%b m1_ack=%b expected 10 1", gnt, m1_ack_o); end
    tick;
    idle_masters;
    tick;
  endtask

  task automatic test_watchdog;
    m0_cyc_i = 1; m0_stb_i = 1;
    tick;
    for (int k = 0; k < 8; k++) begin
      vectors++; if (s_stb_o !== 1'b1 || m0_err_o !== 1'b0) begin miscompares++; $display("FAIL wd_wait%0d: got stb=%b err=%b expected 1 0", k, s_stb_o, m0_err_o); end
      vectors++; if (z_m0_err_o !== 1'b0) begin miscompares++; $display("FAIL wd0_wait%0d: got err=%b expected 0", k, z_m0_err_o); end
      tick;
    end
    vectors++; if (m0_err_o !== 1'b1 || s_stb_o !== 1'b0 || m1_err_o !== 1'b0) begin miscompares++; $display("FAIL wd_fire: got err=%b stb=%b m1_err=%b expected 1 0 0", m0_err_o, s_stb_o, m1_err_o); end
    vectors++; if (z_m0_err_o !== 1'b0 || z_s_stb_o !== 1'b1) begin miscompares++; $display("FAIL wd0_fire: got err=%b stb=%b expected 0 1", z_m0_err_o, z_s_stb_o); end
    tick;
    vectors++; if (m0_err_o !== 1'b0 || s_stb_o !== 1'b1 || gnt !== 2'b01) begin miscompares++; $display("FAIL wd_after: got err=%b stb=%b gnt=%b expected 0 1 01", m0_err_o, s_stb_o, gnt); end
    idle_masters;
    tick;
  endtask

  task automatic test_err_rty;
    m0_cyc_i = 1; m0_stb_i = 1;
    tick;
    s_rty_i = 1;
    #1;
    vectors++; if (m0_rty_o !== 1'b1 || m1_rty_o !== 1'b0 || m0_err_o !== 1'b0) begin miscompares++; $display("FAIL rty_pass: got m0_rty=%b m1_rty=%b m0_err=%b expected 1 0 0", m0_rty_o, m1_rty_o, m0_err_o); end
    tick;
    s_rty_i = 0;
    #1;
    vectors++; if (m0_rty_o !== 1'b0) begin miscompares++; $display("FAIL rty_pulse: got %b expected 0", m0_rty_o); end
    s_err_i = 1;
    #1;
    vectors++; if (m0_err_o !== 1'b1 || m1_err_o !== 1'b0 || m0_ack_o !== 1'b0) begin miscompares++; $display("FAIL err_pass: got m0_err=%b m1_err=%b m0_ack=%b expected 1 0 0", m0_err_o, m1_err_o, m0_ack_o); end
    tick;
    s_err_i = 0;
    #1;
    vectors++; if (m0_err_o !== 1'b0) begin miscompares++; $display("FAIL err_pulse: got %b expected 0", m0_err_o); end
    idle_masters;
    tick;
  endtask

  task automatic test_reset_midop;
    m1_adr_i = 32'h4000_0020;
    m1_cyc_i = 1; m1_stb_i = 1;
    tick;
    vectors++; if (gnt !== 2'b10 || s_cyc_o !== 1'b1) begin miscompares++; $display("FAIL midop_pre: got gnt=%b cyc=%b expected 10 1", gnt, s_cyc_o); end
    #2 reset_n = 0; s_ack_i = 1;
    #1;
    vectors++; if (gnt !== 2'b00 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin miscompares++; $display("FAIL midop_async: got gnt=%b cyc=%b stb=%b expected 00 0 0", gnt, s_cyc_o, s_stb_o); end
    vectors++; if (m1_ack_o !== 1'b0) begin miscompares++; $display("FAIL midop_ack: got %b expected 0", m1_ack_o); end
    idle_masters;
    tick;
    reset_n = 1;
    m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
    tick;
    vectors++; if (gnt !== 2'b01) begin miscompares++; $display("FAIL midop_tie: got %b expected 01", gnt); end
    idle_masters;
    tick;
  endtask

  initial begin
    reset_n = 0;
    m0_adr_i = '0; m0_dat_i = 32'h1111_0000; m0_sel_i = 4'hF; m0_we_i = 0;
    m1_adr_i = '0; m1_dat_i = 32'h2222_0000; m1_sel_i = 4'h3; m1_we_i = 1;
    s_dat_i = '0;
    idle_masters;
    test_reset;
    test_tie;
    test_single;
    test_hold;
    test_watchdog;
    test_err_rty;
    test_reset_midop;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
